// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: pipeline-side bundle for the interrupt sequencer.
// The master modport is the sequencer's view (requests in, stage controls out);
// the slave modport is the pipeline/memory view.
// flagsIn exists only when INT_SAVE_FLAGS_EN is defined.

interface interrupt_sequencer_if #(
  parameter int ADDR_W = 20
);

  logic              interrupt;
  logic              memBusy;
  logic              branchInFlight;
  logic [31:0]       pcCurrent;
`ifdef INT_SAVE_FLAGS_EN
  logic [2:0]        flagsIn;
`endif
  logic [15:0]       vectorData;

  logic              stallFetch;
  logic              flushPipe;
  logic              stackWriteEn;
  logic              spDecrement;
  logic [15:0]       stackData;
  logic              vectorReadEn;
  logic [ADDR_W-1:0] vectorAddr;
  logic              pcLoad;
  logic [31:0]       pcVector;
  logic              intAck;
  logic              busy;

  modport master (
`ifdef INT_SAVE_FLAGS_EN
    input  flagsIn,
`endif
    input  interrupt,
    input  memBusy,
    input  branchInFlight,
    input  pcCurrent,
    input  vectorData,
    output stallFetch,
    output flushPipe,
    output stackWriteEn,
    output spDecrement,
    output stackData,
    output vectorReadEn,
    output vectorAddr,
    output pcLoad,
    output pcVector,
    output intAck,
    output busy
  );

  modport slave (
`ifdef INT_SAVE_FLAGS_EN
    output flagsIn,
`endif
    output interrupt,
    output memBusy,
    output branchInFlight,
    output pcCurrent,
    output vectorData,
    input  stallFetch,
    input  flushPipe,
    input  stackWriteEn,
    input  spDecrement,
    input  stackData,
    input  vectorReadEn,
    input  vectorAddr,
    input  pcLoad,
    input  pcVector,
    input  intAck,
    input  busy
  );

endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: control FSM that takes an external interrupt into the
// 5-stage pipeline. It latches the request edge, waits for a safe point, stalls
// fetch and flushes the front stages, drains in-flight work, pushes the 32-bit
// return PC, reads the 32-bit ISR vector from data memory and loads the PC.
// Optional feature macro: INT_SAVE_FLAGS_EN adds a third push of the CCR flags.

module interrupt_sequencer #(
  parameter int          ADDR_W       = 20,
  parameter int unsigned VECTOR_ADDR  = 0,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic                  clk1,
  input  logic                  reset,
  interrupt_sequencer_if.master bus
);

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int                CNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  // Low half of the vector sits one word above the high half; wraps at 2^ADDR_W.
  localparam logic [ADDR_W-1:0] VEC_ADDR_HI = ADDR_W'(VECTOR_ADDR);
  localparam logic [ADDR_W-1:0] VEC_ADDR_LO = VEC_ADDR_HI + ADDR_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
`ifdef INT_SAVE_FLAGS_EN
    PUSH_FL,
`endif
    VEC_HI,
    VEC_LO,
    JUMP
  } seqState;

  seqState          stateReg;
  seqState          stateNext;
  logic             pendingReg;
  logic             pendingNext;
  logic             interruptDReg;
  logic [31:0]      retAddrReg;
  logic [31:0]      retAddrNext;
  logic [15:0]      vecHiReg;
  logic [15:0]      vecHiNext;
  logic [CNT_W-1:0] drainCntReg;
  logic [CNT_W-1:0] drainCntNext;

  logic             rise;
  logic             hazardFree;

  logic             stallFetch;
  logic             flushPipe;
  logic             stackWriteEn;
  logic [15:0]      stackData;
  logic             vectorReadEn;
  logic [ADDR_W-1:0] vectorAddr;
  logic             pcLoad;
  logic [31:0]      pcVector;
  logic             intAck;
  logic             busy;

  assign rise       = bus.interrupt & ~interruptDReg;
  // Hazards only matter when deciding to start a service.
  assign hazardFree = ~bus.memBusy & ~bus.branchInFlight;

  // Request latch: a new edge sets pending; the JUMP cycle consumes it, but an
  // edge arriving in that very cycle is kept so it is not lost.
  always_comb begin
    pendingNext = pendingReg;
    if (stateReg == JUMP) begin
      pendingNext = 1'b0;
    end
    if (rise) begin
      pendingNext = 1'b1;
    end
  end

  // Next-state and per-state stage controls.
  always_comb begin
    stateNext    = stateReg;
    drainCntNext = drainCntReg;
    retAddrNext  = retAddrReg;
    vecHiNext    = vecHiReg;
    flushPipe    = 1'b0;
    stackWriteEn = 1'b0;
    stackData    = '0;
    vectorReadEn = 1'b0;
    vectorAddr   = '0;
    pcLoad       = 1'b0;
    pcVector     = '0;
    intAck       = 1'b0;

    case (stateReg)
      IDLE: begin
        if (pendingReg && hazardFree) begin
          stateNext   = FLUSH;
          retAddrNext = bus.pcCurrent;
        end
      end

      FLUSH: begin
        flushPipe    = 1'b1;
        drainCntNext = DRAIN_LOAD;
        stateNext    = DRAIN;
      end

      DRAIN: begin
        if (drainCntReg == '0) begin
          stateNext = PUSH_HI;
        end else begin
          drainCntNext = drainCntReg - CNT_W'(1);
        end
      end

      PUSH_HI: begin
        stackWriteEn = 1'b1;
        stackData    = retAddrReg[31:16];
        stateNext    = PUSH_LO;
      end

      PUSH_LO: begin
        stackWriteEn = 1'b1;
        stackData    = retAddrReg[15:0];
`ifdef INT_SAVE_FLAGS_EN
        stateNext    = PUSH_FL;
`else
        stateNext    = VEC_HI;
`endif
      end

`ifdef INT_SAVE_FLAGS_EN
      // The pipeline is drained here, so the live flags are stable.
      PUSH_FL: begin
        stackWriteEn = 1'b1;
        stackData    = {13'b0, bus.flagsIn};
        stateNext    = VEC_HI;
      end
`endif

      VEC_HI: begin
        vectorReadEn = 1'b1;
        vectorAddr   = VEC_ADDR_HI;
        stateNext    = VEC_LO;
      end

      VEC_LO: begin
        // Read data of the VEC_HI strobe arrives this cycle.
        vectorReadEn = 1'b1;
        vectorAddr   = VEC_ADDR_LO;
        vecHiNext    = bus.vectorData;
        stateNext    = JUMP;
      end

      JUMP: begin
        // Low half comes straight from memory read data.
        pcLoad   = 1'b1;
        intAck   = 1'b1;
        pcVector = {vecHiReg, bus.vectorData};
        if (rise && hazardFree) begin
          stateNext   = FLUSH;
          retAddrNext = bus.pcCurrent;
        end else begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any sequence in flight.
  always_ff @(posedge clk1) begin
    if (reset) begin
      stateReg      <= IDLE;
      pendingReg    <= 1'b0;
      interruptDReg <= 1'b0;
      retAddrReg    <= '0;
      vecHiReg      <= '0;
      drainCntReg   <= '0;
    end else begin
      stateReg      <= stateNext;
      pendingReg    <= pendingNext;
      interruptDReg <= bus.interrupt;
      retAddrReg    <= retAddrNext;
      vecHiReg      <= vecHiNext;
      drainCntReg   <= drainCntNext;
    end
  end

  assign stallFetch = (stateReg != IDLE);
  assign busy       = (stateReg != IDLE);

  assign bus.stallFetch   = stallFetch;
  assign bus.flushPipe    = flushPipe;
  assign bus.stackWriteEn = stackWriteEn;
  assign bus.spDecrement  = stackWriteEn;
  assign bus.stackData    = stackData;
  assign bus.vectorReadEn = vectorReadEn;
  assign bus.vectorAddr   = vectorAddr;
  assign bus.pcLoad       = pcLoad;
  assign bus.pcVector     = pcVector;
  assign bus.intAck       = intAck;
  assign bus.busy         = busy;

  // Structural sanity: a stack write and a vector read never share a cycle.
  assert property (@(posedge clk1) !(stackWriteEn && vectorReadEn));
  // The PC load and the acknowledge are the same event.
  assert property (@(posedge clk1) pcLoad == intAck);
  // The vector bus is quiet whenever no PC load is issued.
  assert property (@(posedge clk1) !pcLoad |-> (pcVector == '0));
  // A reset leaves the sequencer idle on the following cycle.
  assert property (@(posedge clk1) reset |=> (stateReg == IDLE));

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: table-driven single service, hand-written multi-cycle
// corner cases and a random soak, all checked against a schedule-based model.

module tb_interrupt_sequencer;

  localparam int          ADDR_W      = 20;
  localparam int unsigned VECTOR_ADDR = 0;
  localparam int          DRAIN       = 3;
`ifdef INT_SAVE_FLAGS_EN
  localparam int          FL          = 1;
`else
  localparam int          FL          = 0;
`endif
  // Cycle offset of JUMP counted from the FLUSH cycle.
  localparam int          LAST        = DRAIN + 5 + FL;
  localparam int          VA_HI_IDX   = int'(VECTOR_ADDR % 4);
  localparam int          VA_LO_IDX   = int'((VECTOR_ADDR + 1) % 4);

  typedef struct packed {
    logic              stallFetch;
    logic              flushPipe;
    logic              stackWriteEn;
    logic              spDecrement;
    logic [15:0]       stackData;
    logic              vectorReadEn;
    logic [ADDR_W-1:0] vectorAddr;
    logic              pcLoad;
    logic [31:0]       pcVector;
    logic              intAck;
    logic              busy;
  } outs_t;

  typedef struct {
    logic        intr;
    logic        mb;
    logic        bif;
    logic [31:0] pc;
    outs_t       exp;
  } vec_t;

  logic clk1  = 1'b0;
  logic reset = 1'b1;
  always #5 clk1 = ~clk1;

  interrupt_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  logic [2:0] flagsDrv = 3'b000;
`ifdef INT_SAVE_FLAGS_EN
  assign bus.flagsIn = flagsDrv;
`endif

  // Data memory with one-cycle synchronous read.
  logic [15:0] mem [0:3];
  logic [15:0] memData = 16'h0000;
  assign bus.vectorData = memData;
  always @(posedge clk1) begin
    if (bus.vectorReadEn) memData <= mem[bus.vectorAddr[1:0]];
  end

  interrupt_sequencer #(
    .ADDR_W      (ADDR_W),
    .VECTOR_ADDR (VECTOR_ADDR),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk1 (clk1),
    .reset(reset),
    .bus  (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          ackCount    = 0;
  int          flushCount  = 0;
  int          ackCycles[$];
  int          flushCycles[$];
  logic [15:0] pushes[$];
  outs_t       lastAct;

  // Reference model: -1 when idle, else cycles elapsed since FLUSH.
  int          mSvc     = -1;
  logic        mPending = 1'b0;
  logic        mPrevInt = 1'b0;
  logic [31:0] mRet     = '0;

  function automatic outs_t sampleOuts();
    outs_t o;
    o.stallFetch   = bus.stallFetch;
    o.flushPipe    = bus.flushPipe;
    o.stackWriteEn = bus.stackWriteEn;
    o.spDecrement  = bus.spDecrement;
    o.stackData    = bus.stackData;
    o.vectorReadEn = bus.vectorReadEn;
    o.vectorAddr   = bus.vectorAddr;
    o.pcLoad       = bus.pcLoad;
    o.pcVector     = bus.pcVector;
    o.intAck       = bus.intAck;
    o.busy         = bus.busy;
    return o;
  endfunction

  function automatic outs_t expOf(logic stall, logic flush, logic push, logic [15:0] sd,
                                  logic vre, logic [ADDR_W-1:0] va, logic ack, logic [31:0] pcv);
    outs_t e;
    e.stallFetch   = stall;
    e.flushPipe    = flush;
    e.stackWriteEn = push;
    e.spDecrement  = push;
    e.stackData    = sd;
    e.vectorReadEn = vre;
    e.vectorAddr   = va;
    e.pcLoad       = ack;
    e.pcVector     = pcv;
    e.intAck       = ack;
    e.busy         = stall;
    return e;
  endfunction

  function automatic vec_t mkRow(logic intr, logic [31:0] pc, outs_t e);
    vec_t r;
    r.intr = intr;
    r.mb   = 1'b0;
    r.bif  = 1'b0;
    r.pc   = pc;
    r.exp  = e;
    return r;
  endfunction

  function automatic outs_t modelExpect();
    outs_t e;
    e = '0;
    if (mSvc >= 0) begin
      e.stallFetch = 1'b1;
      e.busy       = 1'b1;
    end
    if (mSvc == 0) e.flushPipe = 1'b1;
    if (mSvc >= DRAIN + 1 && mSvc <= DRAIN + 2 + FL) begin
      e.stackWriteEn = 1'b1;
      e.spDecrement  = 1'b1;
      if (mSvc == DRAIN + 1)      e.stackData = mRet[31:16];
      else if (mSvc == DRAIN + 2) e.stackData = mRet[15:0];
      else                        e.stackData = {13'b0, flagsDrv};
    end
    if (mSvc == DRAIN + 3 + FL) begin
      e.vectorReadEn = 1'b1;
      e.vectorAddr   = ADDR_W'(VECTOR_ADDR);
    end
    if (mSvc == DRAIN + 4 + FL) begin
      e.vectorReadEn = 1'b1;
      e.vectorAddr   = ADDR_W'(VECTOR_ADDR + 1);
    end
    if (mSvc == LAST) begin
      e.pcLoad   = 1'b1;
      e.intAck   = 1'b1;
      e.pcVector = {mem[VA_HI_IDX], mem[VA_LO_IDX]};
    end
    return e;
  endfunction

  task automatic modelUpdate();
    logic rise;
    logic hf;
    int   old;
    rise = bus.interrupt & ~mPrevInt;
    hf   = ~bus.memBusy & ~bus.branchInFlight;
    if (reset) begin
      mSvc     = -1;
      mPending = 1'b0;
      mPrevInt = 1'b0;
      mRet     = '0;
    end else begin
      old = mSvc;
      if (old < 0) begin
        if (mPending && hf) begin
          mSvc = 0;
          mRet = bus.pcCurrent;
        end
      end else if (old == LAST) begin
        if (rise && hf) begin
          mSvc = 0;
          mRet = bus.pcCurrent;
        end else begin
          mSvc = -1;
        end
      end else begin
        mSvc = mSvc + 1;
      end
      if (rise)             mPending = 1'b1;
      else if (old == LAST) mPending = 1'b0;
      mPrevInt = bus.interrupt;
    end
  endtask

  task automatic chkOuts(input string name, input outs_t act, input outs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: sample just after the falling edge, commit the model at the
  // rising edge, return at the next falling edge ready for new inputs.
  task automatic tick(input bit useTab, input outs_t tabExp);
    outs_t act;
    #1;
    act = sampleOuts();
    chkOuts("model", act, modelExpect());
    if (useTab) chkOuts("table", act, tabExp);
    if (act.intAck) begin
      ackCount++;
      ackCycles.push_back(cyc);
      $display("service %0d at cycle %0d: pcVector=%h", ackCount, cyc, act.pcVector);
    end
    if (act.flushPipe) begin
      flushCount++;
      flushCycles.push_back(cyc);
    end
    if (act.stackWriteEn) pushes.push_back(act.stackData);
    lastAct = act;
    @(posedge clk1);
    modelUpdate();
    @(negedge clk1);
    cyc++;
  endtask

  task automatic step();
    tick(1'b0, '0);
  endtask

  task automatic drive(input logic intr, input logic mb, input logic bif, input logic [31:0] pc);
    bus.interrupt      = intr;
    bus.memBusy        = mb;
    bus.branchInFlight = bif;
    bus.pcCurrent      = pc;
  endtask

  task automatic hazardTest(input bit useBranch, input logic [31:0] pcFinal);
    int fc;
    int f0;
    pushes.delete();
    f0 = flushCount;
    drive(1'b1, 1'b0, 1'b0, 32'hAAAA_0001);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, !useBranch, useBranch, 32'hBBBB_0000 + i);
      step();
    end
    chkInt("hazardNoFlush", flushCount - f0, 0);
    drive(1'b0, 1'b0, 1'b0, pcFinal);
    fc = cyc;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (LAST + 2) step();
    chkInt("hazardFlushCycle", flushCycles[$], fc + 1);
    chkInt("hazardPushHi", int'(pushes[0]), int'(pcFinal[31:16]));
    chkInt("hazardPushLo", int'(pushes[1]), int'(pcFinal[15:0]));
  endtask

  vec_t tbl[$];

  initial begin
    int a0;
    int f0;
    int jc;

    mem[0] = 16'h0000;
    mem[1] = 16'h0100;
    mem[2] = 16'h5A5A;
    mem[3] = 16'hA5A5;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk1);
    @(negedge clk1);

    // Reset state.
    step();
    step();
    reset = 1'b0;
    step();

    // Single service, table driven.
    tbl.push_back(mkRow(1'b1, 32'h0000_1234, expOf(0, 0, 0, 16'h0000, 0, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0000_1234, expOf(0, 0, 0, 16'h0000, 0, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0000_9999, expOf(1, 1, 0, 16'h0000, 0, 20'h0, 0, 32'h0)));
    for (int i = 0; i < DRAIN; i++)
      tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 0, 16'h0000, 0, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 1, 16'h0000, 0, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 1, 16'h1234, 0, 20'h0, 0, 32'h0)));
    if (FL == 1)
      tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 1, 16'h0000, 0, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 0, 16'h0000, 1, 20'h0, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 0, 16'h0000, 1, 20'h1, 0, 32'h0)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(1, 0, 0, 16'h0000, 0, 20'h0, 1, 32'h0000_0100)));
    tbl.push_back(mkRow(1'b0, 32'h0, expOf(0, 0, 0, 16'h0000, 0, 20'h0, 0, 32'h0)));
    a0 = ackCount;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].intr, tbl[i].mb, tbl[i].bif, tbl[i].pc);
      tick(1'b1, tbl[i].exp);
    end
    chkInt("singleAckCount", ackCount - a0, 1);
    chkInt("singleLatency", ackCycles[$] - flushCycles[$], 8 + FL);

    // Hazard hold with memBusy, then with branchInFlight.
    hazardTest(1'b0, 32'hCAFE_0042);
    hazardTest(1'b1, 32'h1357_9BDF);

    // Level held high: serviced once.
    a0 = ackCount;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_7777);
    repeat (30) step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    chkInt("levelAckCount", ackCount - a0, 1);
    chkInt("levelBusyAfter", int'(lastAct.busy), 0);

    // Back-to-back: new edge in the JUMP cycle.
    a0 = ackCount;
    drive(1'b1, 1'b0, 1'b0, 32'h0001_0000);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0001_0000);
    repeat (LAST + 1) step();
    drive(1'b1, 1'b0, 1'b0, 32'h0002_0000);
    jc = cyc;
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (LAST + 4) step();
    chkInt("b2bAckCount", ackCount - a0, 2);
    chkInt("b2bFlushAfterJump", flushCycles[$], jc + 1);
    chkInt("b2bAckSpacing", ackCycles[$] - ackCycles[$-1], LAST + 1);

    // Reset in PUSH_LO aborts the sequence.
    drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    repeat (DRAIN + 3) step();
    chkInt("preResetInPushLo", int'(lastAct.stackData), 16'hDEAD);
    reset = 1'b1;
    step();
    reset = 1'b0;
    a0 = ackCount;
    f0 = flushCount;
    step();
    chkOuts("afterResetOutputs", lastAct, '0);
    repeat (14) step();
    chkInt("resetNoAck", ackCount - a0, 0);
    chkInt("resetNoFlush", flushCount - f0, 0);

`ifdef INT_SAVE_FLAGS_EN
    // Flags saved as a third push.
    pushes.delete();
    flagsDrv = 3'b101;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (LAST + 3) step();
    chkInt("flagsPushCount", pushes.size(), 3);
    chkInt("flagsPushLo", int'(pushes[1]), 16'h1234);
    chkInt("flagsPushFl", int'(pushes[2]), 16'h0005);
    chkInt("flagsLatency", ackCycles[$] - flushCycles[$], 9);
`endif

    // Random soak against the model.
    mem[VA_HI_IDX] = 16'($urandom);
    mem[VA_LO_IDX] = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15, $urandom);
      flagsDrv = 3'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (LAST + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
